param_data_mem: RTL and testbench

Parametrised single-port data memory for the RISC datapath; the next generation of the core's word-addressed data memory. It adds configurable data and address widths, per-byte write enables, and a multi-cycle hardware initialisation sweep that fills every word with its own index. The sweep runs after asynchronous reset or on a software request, and a `busy` flag lets the control unit stall during it. It sits between the ALU/address path and the register-file write-back mux, in the same place as the existing data memory.

---
 rtl/param_data_mem.sv | 128 ++++++++++++
 tb/tb_param_data_mem.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/param_data_mem.sv
// Parametrised single-port data memory with per-byte write enables and a
// self-index initialisation sweep. Optional registered read port: PARAM_DATA_MEM_REG_OUT_EN.
module param_data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                MW,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                init_req,
  output logic [DATA_W-1:0]   out,
  output logic                busy,
  output logic                wr_drop
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_s;
  logic                wr_drop_r, drop_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Replace only the enabled byte lanes of a word.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NB-1:0]     lanes
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < NB; b++) begin
      if (lanes[b]) res[8*b +: 8] = new_word[8*b +: 8];
      else          res[8*b +: 8] = old_word[8*b +: 8];
    end
    return res;
  endfunction

  // Next-state, sweep counter and memory write-port selection.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr;
    mem_wdata_s = data_in;
    case (state_r)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_r;
        mem_wdata_s = DATA_W'(cnt_r);
        if (cnt_r == {ADDR_W{1'b1}}) begin
          state_s = ST_IDLE;
          cnt_s   = {ADDR_W{1'b0}};
        end else begin
          cnt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_s = ST_INIT;
          cnt_s   = {ADDR_W{1'b0}};
        end else if (MW && (BE != {NB{1'b0}})) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = merge_lanes(mem[addr], data_in, BE);
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // A real write (some lane enabled) is lost while sweeping or when init wins the edge.
  assign drop_s = MW && (BE != {NB{1'b0}}) && ((state_r == ST_INIT) || init_req);

  // Control state; reset restarts the sweep from word 0.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_INIT;
      cnt_r     <= {ADDR_W{1'b0}};
      wr_drop_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      wr_drop_r <= drop_s;
    end
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) mem[mem_waddr_s] <= mem_wdata_s;
  end

  assign busy    = (state_r == ST_INIT);
  assign wr_drop = wr_drop_r;

`ifdef PARAM_DATA_MEM_REG_OUT_EN
  logic [DATA_W-1:0] out_r;

  // Read-first registered port, blanked whenever the next cycle is a sweep cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      out_r <= {DATA_W{1'b0}};
    end else begin
      out_r <= (state_s == ST_INIT) ? {DATA_W{1'b0}} : mem[addr];
    end
  end

  assign out = out_r;
`else
  assign out = busy ? {DATA_W{1'b0}} : mem[addr];
`endif

endmodule

// File: tb/tb_param_data_mem.sv
// Directed self-checking bench for param_data_mem at default parameters.
module tb_param_data_mem;

  logic        CLK;
  logic        reset;
  logic [5:0]  addr;
  logic        MW;
  logic [3:0]  BE;
  logic [31:0] data_in;
  logic        init_req;
  logic [31:0] out;
  logic        busy;
  logic        wr_drop;

  int n_cmp;
  int n_err;
  int n_edges;
  int n_drops;

  param_data_mem #(.DATA_W(32), .ADDR_W(6)) dut (
    .CLK(CLK), .reset(reset), .addr(addr), .MW(MW), .BE(BE),
    .data_in(data_in), .init_req(init_req), .out(out),
    .busy(busy), .wr_drop(wr_drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count edges until busy drops, and how many of those cycles showed wr_drop.
  task automatic wait_idle(output int edges, output int drops);
    edges = 0;
    drops = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #1;
      edges++;
      if (wr_drop) drops++;
      if (!busy) break;
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; data_in = d; BE = be; MW = 1'b1;
    @(posedge CLK);
    #1;
    MW = 1'b0; BE = 4'h0;
  endtask

  task automatic check_read(input string tag, input logic [5:0] a, input logic [31:0] exp);
    addr = a;
`ifdef PARAM_DATA_MEM_REG_OUT_EN
    @(posedge CLK);
`endif
    #1;
    check(tag, out, exp);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0; addr = 6'd0; MW = 1'b0; BE = 4'h0;
    data_in = 32'h0; init_req = 1'b0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_drop", {31'd0, wr_drop}, 32'd0);
    check("rst_out", out, 32'd0);

    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b1;
    wait_idle(n_edges, n_drops);
    check("boot_busy_edges", n_edges, 32'd64);
    check("boot_drops", n_drops, 32'd0);
    check_read("boot_rd0", 6'd0, 32'd0);
    check_read("boot_rd17", 6'd17, 32'd17);
    check_read("boot_rd63", 6'd63, 32'd63);

    // MW with no lanes enabled: no write, no drop.
    do_write(6'd3, 32'hFFFFFFFF, 4'h0);
    check("be0_drop", {31'd0, wr_drop}, 32'd0);
    check_read("be0_rd3", 6'd3, 32'd3);

    do_write(6'd5, 32'hAABBCCDD, 4'b0101);
    check("bw1_drop", {31'd0, wr_drop}, 32'd0);
    check_read("bw1_rd5", 6'd5, 32'h00BB00DD);
    do_write(6'd5, 32'h11223344, 4'b1010);
    check_read("bw2_rd5", 6'd5, 32'h11BB33DD);

`ifdef PARAM_DATA_MEM_REG_OUT_EN
    do_write(6'd9, 32'hDEADBEEF, 4'hF);
    addr = 6'd9;
    check("rf_old", out, 32'd9);
    @(posedge CLK);
    #1;
    check("rf_new", out, 32'hDEADBEEF);
`else
    addr = 6'd12; data_in = 32'hCAFEF00D; BE = 4'hF; MW = 1'b1;
    #1;
    check("rw_before", out, 32'd12);
    @(posedge CLK);
    #1;
    MW = 1'b0; BE = 4'h0;
    check("rw_after", out, 32'hCAFEF00D);
`endif

    // init_req and a write on the same edge: init wins, write dropped.
    init_req = 1'b1; MW = 1'b1; BE = 4'hF; addr = 6'd2; data_in = 32'h12345678;
    @(posedge CLK);
    #1;
    init_req = 1'b0; MW = 1'b0; BE = 4'h0;
    check("req_drop", {31'd0, wr_drop}, 32'd1);
    check("req_busy", {31'd0, busy}, 32'd1);
    check("req_out0", out, 32'd0);
    wait_idle(n_edges, n_drops);
    check("req_busy_edges", n_edges, 32'd64);
    check("req_drop_once", n_drops, 32'd0);
    check_read("req_rd2", 6'd2, 32'd2);

    // Corrupt a word, then reset in the middle of a sweep.
    do_write(6'd40, 32'hFFFFFFFF, 4'hF);
    check_read("cor_rd40", 6'd40, 32'hFFFFFFFF);
    init_req = 1'b1;
    @(posedge CLK);
    #1;
    init_req = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    reset = 1'b0;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_out0", out, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b1;
    wait_idle(n_edges, n_drops);
    check("mid_busy_edges", n_edges, 32'd64);
    check_read("mid_rd40", 6'd40, 32'd40);

    // Write held across a whole sweep: dropped on every sweep cycle.
    init_req = 1'b1; MW = 1'b1; BE = 4'hF; addr = 6'd7; data_in = 32'hFFFFFFFF;
    @(posedge CLK);
    #1;
    init_req = 1'b0;
    check("hold_drop0", {31'd0, wr_drop}, 32'd1);
    wait_idle(n_edges, n_drops);
    MW = 1'b0; BE = 4'h0;
    check("hold_busy_edges", n_edges, 32'd64);
    check("hold_drops", n_drops, 32'd64);
    for (int i = 0; i < 64; i++) begin
      check_read("hold_rd", 6'(i), 32'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
